// File: rtl/serdes_align_pkg.sv
// Shared types and sync-header helpers for the 128b/130b receive block aligner.
package serdes_align_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_e;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_OS   = 2'b01;

  function automatic logic hdr_good(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_OS);
  endfunction

endpackage

// File: rtl/serdes_align_err_window.sv
// Loss-of-lock window: counts blocks and bad headers per window and flags re-hunt.
module serdes_align_err_window #(
  parameter int UNLOCK_WIN = 64,
  parameter int UNLOCK_BAD = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_eval,
  input  logic i_bad,
  output logic o_unlock
);

  localparam int BLK_W = $clog2(UNLOCK_WIN);
  localparam int BAD_W = $clog2(UNLOCK_BAD + 1);

  logic [BLK_W-1:0] r_blk_cnt;
  logic [BAD_W-1:0] r_bad_cnt;
  logic [BAD_W-1:0] w_bad_sum;

  // The current block joins the tally before it is compared against the limit.
  always_comb begin
    w_bad_sum = r_bad_cnt + BAD_W'(i_bad);
    o_unlock  = i_eval && (w_bad_sum >= BAD_W'(UNLOCK_BAD));
  end

  // Window counters; a window wrap clears the tally only after the compare above.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_blk_cnt <= '0;
      r_bad_cnt <= '0;
    end else if (i_eval) begin
      if (o_unlock || (r_blk_cnt == BLK_W'(UNLOCK_WIN - 1))) begin
        r_blk_cnt <= '0;
        r_bad_cnt <= '0;
      end else begin
        r_blk_cnt <= r_blk_cnt + 1'b1;
        r_bad_cnt <= w_bad_sum;
      end
    end else begin
      r_blk_cnt <= r_blk_cnt;
      r_bad_cnt <= r_bad_cnt;
    end
  end

endmodule

// File: rtl/serdes_rx_block_aligner.sv
// Serial-to-130b block aligner with sync-header hunt/verify/lock.
// Optional statistics counters are built when SERDES_RX_ALIGN_STATS_EN is defined.
module serdes_rx_block_aligner
  import serdes_align_pkg::*;
#(
  parameter int P_WIDTH       = 130,
  parameter int LOCK_GOOD_CNT = 8,
  parameter int UNLOCK_WIN    = 64,
  parameter int UNLOCK_BAD    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               serial_in,
`ifdef SERDES_RX_ALIGN_STATS_EN
  input  logic               stat_clr,
  output logic [15:0]        stat_bad_hdr,
  output logic [15:0]        stat_lock_loss,
`endif
  output logic [P_WIDTH-1:0] rx_block,
  output logic               rx_block_valid,
  output logic               hdr_error,
  output logic               lock,
  output logic [1:0]         align_state
);

  localparam int CNT_W  = $clog2(P_WIDTH);
  localparam int GOOD_W = $clog2(LOCK_GOOD_CNT + 1);

  // Only P_WIDTH-1 history bits are kept; the incoming bit completes the window.
  logic [P_WIDTH-2:0] r_win;
  logic [CNT_W-1:0]   r_fill_cnt;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [GOOD_W-1:0]  r_good_cnt;
  align_state_e       r_state;
  logic [P_WIDTH-1:0] r_block;
  logic               r_valid;
  logic               r_hdr_err;
  logic               r_lock;

  logic [P_WIDTH-1:0] w_nwin;
  logic               w_hdr_good;
  logic               w_full;
  logic               w_boundary;
  logic               w_emit;
  logic               w_unlock;
  align_state_e       w_state_nxt;
  logic [CNT_W-1:0]   w_bit_cnt_nxt;
  logic [GOOD_W-1:0]  w_good_cnt_nxt;

  assign w_nwin     = {r_win, serial_in};
  assign w_hdr_good = hdr_good(w_nwin[P_WIDTH-1:P_WIDTH-2]);
  assign w_full     = (r_fill_cnt == CNT_W'(P_WIDTH - 1));
  assign w_boundary = (r_bit_cnt == CNT_W'(P_WIDTH - 1));
  assign w_emit     = (r_state == LOCKED) && w_boundary;

  serdes_align_err_window #(
    .UNLOCK_WIN (UNLOCK_WIN),
    .UNLOCK_BAD (UNLOCK_BAD)
  ) u_err_window (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_clr    (r_state != LOCKED),
    .i_eval   (w_emit),
    .i_bad    (!w_hdr_good),
    .o_unlock (w_unlock)
  );

  // Alignment FSM next-state; HUNT slips one bit per cycle, other states act at boundaries.
  always_comb begin
    w_state_nxt    = r_state;
    w_good_cnt_nxt = r_good_cnt;
    if (w_boundary) begin
      w_bit_cnt_nxt = '0;
    end else begin
      w_bit_cnt_nxt = r_bit_cnt + 1'b1;
    end
    case (r_state)
      HUNT: begin
        if (w_full && w_hdr_good) begin
          w_state_nxt    = VERIFY;
          w_bit_cnt_nxt  = '0;
          w_good_cnt_nxt = GOOD_W'(1);
        end else begin
          w_good_cnt_nxt = '0;
        end
      end
      VERIFY: begin
        if (!w_boundary) begin
          w_state_nxt = VERIFY;
        end else if (w_hdr_good) begin
          w_good_cnt_nxt = r_good_cnt + 1'b1;
          if (r_good_cnt == GOOD_W'(LOCK_GOOD_CNT - 1)) begin
            w_state_nxt = LOCKED;
          end else begin
            w_state_nxt = VERIFY;
          end
        end else begin
          w_state_nxt    = HUNT;
          w_good_cnt_nxt = '0;
        end
      end
      LOCKED: begin
        if (w_emit && w_unlock) begin
          w_state_nxt    = HUNT;
          w_good_cnt_nxt = '0;
        end else begin
          w_state_nxt = LOCKED;
        end
      end
      default: begin
        w_state_nxt    = HUNT;
        w_good_cnt_nxt = '0;
      end
    endcase
  end

  // State, counters and registered outputs; the offending block is still emitted on unlock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_win      <= '0;
      r_fill_cnt <= '0;
      r_bit_cnt  <= '0;
      r_good_cnt <= '0;
      r_state    <= HUNT;
      r_block    <= '0;
      r_valid    <= 1'b0;
      r_hdr_err  <= 1'b0;
      r_lock     <= 1'b0;
    end else begin
      r_win      <= w_nwin[P_WIDTH-2:0];
      r_fill_cnt <= w_full ? r_fill_cnt : r_fill_cnt + 1'b1;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_good_cnt <= w_good_cnt_nxt;
      r_state    <= w_state_nxt;
      r_block    <= w_emit ? w_nwin : r_block;
      r_valid    <= w_emit;
      r_hdr_err  <= w_emit && !w_hdr_good;
      r_lock     <= (w_state_nxt == LOCKED);
    end
  end

  assign rx_block       = r_block;
  assign rx_block_valid = r_valid;
  assign hdr_error      = r_hdr_err;
  assign lock           = r_lock;
  assign align_state    = r_state;

`ifdef SERDES_RX_ALIGN_STATS_EN
  logic [15:0] r_stat_bad;
  logic [15:0] r_stat_loss;
  logic        w_bad_seen;
  logic        w_loss;

  assign w_bad_seen = w_boundary && !w_hdr_good && ((r_state == VERIFY) || (r_state == LOCKED));
  assign w_loss     = w_emit && w_unlock;

  // Saturating statistics; a clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr) begin
      r_stat_bad  <= 16'h0000;
      r_stat_loss <= 16'h0000;
    end else begin
      r_stat_bad  <= (w_bad_seen && (r_stat_bad != 16'hFFFF)) ? r_stat_bad + 16'h0001 : r_stat_bad;
      r_stat_loss <= (w_loss && (r_stat_loss != 16'hFFFF)) ? r_stat_loss + 16'h0001 : r_stat_loss;
    end
  end

  assign stat_bad_hdr   = r_stat_bad;
  assign stat_lock_loss = r_stat_loss;
`endif

endmodule
